// File: rtl/stream_pkg.sv
// Shared stream definitions for the FIFO read serializer.
//   beat_order_e : order in which slices of a wide word leave the serializer
//   state_e      : serializer control state (IDLE = nothing held, SHIFT = word held)
//   cnt_width()  : width of a beat index for a given ratio, never below one bit
package stream_pkg;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } beat_order_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_read_serializer.sv
// Reader end of a synchronous show-ahead FIFO. Pops IN_WIDTH-bit words and
// emits each one as IN_WIDTH/OUT_WIDTH beats on a valid/ready stream, with
// m_last_o marking the final beat of every word. Sustains one beat per cycle,
// including across word boundaries.
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous active-high reset
//   fifo_rd_en_o   out  pop strobe to the FIFO (combinational)
//   fifo_rd_data_i in   FIFO head word, valid whenever fifo_empty_i = 0
//   fifo_empty_i   in   FIFO empty flag
//   m_valid_o      out  beat valid (registered)
//   m_ready_i      in   consumer ready
//   m_data_o       out  current beat (registered source)
//   m_last_o       out  final beat of the current word
module fifo_read_serializer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 fifo_rd_en_o,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data_i,
    input  logic                 fifo_empty_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [OUT_WIDTH-1:0] m_data_o,
    output logic                 m_last_o
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = cnt_width(RATIO);
    localparam beat_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 1) begin : g_bad_ratio
        $error("fifo_read_serializer: IN_WIDTH must be a positive multiple of OUT_WIDTH");
    end

    state_e               state_q;
    logic [IN_WIDTH-1:0]  hold_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     sel;
    logic                 valid_q;
    logic                 last;
    logic                 accept;
    logic [OUT_WIDTH-1:0] slices [RATIO];

    assign valid_q = (state_q == ST_SHIFT);
    assign last    = (cnt_q == CNT_LAST);
    assign accept  = valid_q & m_ready_i;

    // Pop when nothing is held, or when the last beat of the held word leaves
    // this cycle; the second case is what removes the bubble between words.
    assign fifo_rd_en_o = ~rst_i & ~fifo_empty_i & (~valid_q | (accept & last));

    // Outputs come only from state, so the stream side has no input-to-output path.
    assign m_valid_o = valid_q;
    assign m_last_o  = valid_q & last;

    for (genvar i = 0; i < RATIO; i++) begin : g_slice
        assign slices[i] = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
    end

    assign sel      = (ORDER == ORDER_MSB_FIRST) ? (CNT_LAST - cnt_q) : cnt_q;
    assign m_data_o = slices[sel];

    // hold_q is cleared too, so m_data_o reads zero right after reset.
    // A pop has priority: it covers both the IDLE load and the back-to-back
    // reload on the last accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else if (fifo_rd_en_o) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            hold_q  <= fifo_rd_data_i;
        end else if (accept) begin
            if (last) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Bench for fifo_read_serializer: three instances (LSB-first 32->8,
// MSB-first 32->8, and 32->32) each fed by a small depth-4 show-ahead FIFO
// model, driven with directed vectors.
module tb_fifo_read_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO models, one per instance
    logic [31:0] mem [3][4];
    logic [1:0]  wp [3];
    logic [1:0]  rp [3];
    logic [2:0]  cnt [3];
    logic [2:0]  push_en;
    logic [31:0] push_d [3];
    logic [2:0]  empty;
    logic [31:0] head [3];
    logic [2:0]  rd_en;
    logic        rd0, rd1, rd2;
    logic [2:0]  ready;

    logic        v0, l0, v1, l1, v2, l2;
    logic [7:0]  d0, d1;
    logic [31:0] d2;

    assign rd_en = {rd2, rd1, rd0};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            empty[i] = (cnt[i] == 3'd0);
            head[i]  = mem[i][rp[i]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push_en[i]) begin
                mem[i][wp[i]] <= push_d[i];
                wp[i]         <= wp[i] + 2'd1;
            end
            if (rd_en[i])
                rp[i] <= rp[i] + 2'd1;
            cnt[i] <= cnt[i] + 3'(push_en[i]) - 3'(rd_en[i]);
        end
    end

    fifo_read_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk_i(clk), .rst_i(rst), .fifo_rd_en_o(rd0), .fifo_rd_data_i(head[0]),
        .fifo_empty_i(empty[0]), .m_valid_o(v0), .m_ready_i(ready[0]),
        .m_data_o(d0), .m_last_o(l0));

    fifo_read_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk_i(clk), .rst_i(rst), .fifo_rd_en_o(rd1), .fifo_rd_data_i(head[1]),
        .fifo_empty_i(empty[1]), .m_valid_o(v1), .m_ready_i(ready[1]),
        .m_data_o(d1), .m_last_o(l1));

    fifo_read_serializer #(.IN_WIDTH(32), .OUT_WIDTH(32), .MSB_FIRST(0)) u_r1 (
        .clk_i(clk), .rst_i(rst), .fifo_rd_en_o(rd2), .fifo_rd_data_i(head[2]),
        .fifo_empty_i(empty[2]), .m_valid_o(v2), .m_ready_i(ready[2]),
        .m_data_o(d2), .m_last_o(l2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [31:0] w);
        push_en[i] = 1'b1;
        push_d[i]  = w;
        tick();
        push_en[i] = 1'b0;
    endtask

    // Expect a valid beat on the LSB-first instance, then advance one cycle.
    task automatic beat0(input string tag, input logic [7:0] d, input logic l, input logic rd);
        #1;
        check({tag, " valid"}, 32'(v0), 32'd1);
        check({tag, " data"},  32'(d0), 32'(d));
        check({tag, " last"},  32'(l0), 32'(l));
        check({tag, " rd_en"}, 32'(rd0), 32'(rd));
        tick();
    endtask

    task automatic idle0(input string tag);
        #1;
        check({tag, " valid"}, 32'(v0), 32'd0);
        check({tag, " last"},  32'(l0), 32'd0);
    endtask

    // A pop strobe must never coincide with an empty FIFO.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (empty[i])
                check($sformatf("pop_when_empty[%0d]", i), 32'(rd_en[i]), 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            wp[i] = '0; rp[i] = '0; cnt[i] = '0; push_d[i] = '0;
        end
        push_en = '0;
        ready   = 3'b111;
        rst     = 1'b1;
        tick();
        tick();

        // 1: reset state, pop held off during reset even with data queued
        check("rst valid", 32'(v0), 32'd0);
        check("rst data",  32'(d0), 32'd0);
        check("rst last",  32'(l0), 32'd0);
        push(0, 32'hA1B2C3D4);
        #1;
        check("rst rd_en blocked", 32'(rd0), 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst valid", 32'(v0), 32'd0);
        check("post-rst data",  32'(d0), 32'd0);
        check("t1 pop", 32'(rd0), 32'd1);
        tick();
        beat0("t1 b0", 8'hD4, 1'b0, 1'b0);
        beat0("t1 b1", 8'hC3, 1'b0, 1'b0);
        beat0("t1 b2", 8'hB2, 1'b0, 1'b0);
        beat0("t1 b3", 8'hA1, 1'b1, 1'b0);
        idle0("t1 end");

        // 2: two queued words, no bubble, second pop on beat 03
        push(0, 32'h03020100);
        push(0, 32'h07060504);
        for (int k = 0; k < 8; k++)
            beat0($sformatf("t2 b%0d", k), 8'(k), (k == 3 || k == 7), (k == 3));
        idle0("t2 end");

        // 3: back-pressure while B2 is presented
        push(0, 32'hA1B2C3D4);
        #1;
        check("t3 pop", 32'(rd0), 32'd1);
        tick();
        beat0("t3 b0", 8'hD4, 1'b0, 1'b0);
        beat0("t3 b1", 8'hC3, 1'b0, 1'b0);
        ready[0] = 1'b0;
        for (int k = 0; k < 3; k++)
            beat0($sformatf("t3 stall%0d", k), 8'hB2, 1'b0, 1'b0);
        ready[0] = 1'b1;
        beat0("t3 b2", 8'hB2, 1'b0, 1'b0);
        beat0("t3 b3", 8'hA1, 1'b1, 1'b0);

        // 4: FIFO dry, long idle, then first beat one cycle after the pop
        for (int k = 0; k < 10; k++) begin
            idle0($sformatf("t4 idle%0d", k));
            check($sformatf("t4 rd_en%0d", k), 32'(rd0), 32'd0);
            tick();
        end
        push(0, 32'h11223344);
        #1;
        check("t4 pop", 32'(rd0), 32'd1);
        tick();
        beat0("t4 b0", 8'h44, 1'b0, 1'b0);
        beat0("t4 b1", 8'h33, 1'b0, 1'b0);
        beat0("t4 b2", 8'h22, 1'b0, 1'b0);
        beat0("t4 b3", 8'h11, 1'b1, 1'b0);
        idle0("t4 end");

        // 5: reset mid-word discards B2/A1, queued word survives
        push(0, 32'hA1B2C3D4);
        tick();
        beat0("t5 b0", 8'hD4, 1'b0, 1'b0);
        beat0("t5 b1", 8'hC3, 1'b0, 1'b0);
        rst = 1'b1;
        push_en[0] = 1'b1;
        push_d[0]  = 32'h55667788;
        #1;
        check("t5 rd_en in rst", 32'(rd0), 32'd0);
        tick();
        push_en[0] = 1'b0;
        rst = 1'b0;
        idle0("t5 after rst");
        check("t5 data after rst", 32'(d0), 32'd0);
        check("t5 pop", 32'(rd0), 32'd1);
        tick();
        beat0("t5 b0'", 8'h88, 1'b0, 1'b0);
        beat0("t5 b1'", 8'h77, 1'b0, 1'b0);
        beat0("t5 b2'", 8'h66, 1'b0, 1'b0);
        beat0("t5 b3'", 8'h55, 1'b1, 1'b0);
        idle0("t5 end");

        // 6a: MSB-first order
        push(1, 32'hA1B2C3D4);
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = 32'hA1B2C3D4;
            #1;
            check($sformatf("t6a valid%0d", k), 32'(v1), 32'd1);
            check($sformatf("t6a data%0d", k), 32'(d1), 32'(w[(3-k)*8 +: 8]));
            check($sformatf("t6a last%0d", k), 32'(l1), 32'(k == 3));
            tick();
        end
        #1;
        check("t6a end valid", 32'(v1), 32'd0);

        // 6b: ratio 1, one word per cycle, last on every beat
        begin
            logic [31:0] words [4];
            words[0] = 32'hDEADBEEF; words[1] = 32'h01234567;
            words[2] = 32'h89ABCDEF; words[3] = 32'hCAFEF00D;
            push(2, words[0]);
            push(2, words[1]);
            for (int k = 0; k < 4; k++) begin
                push_en[2] = (k < 2);
                push_d[2]  = words[(k + 2) % 4];
                #1;
                check($sformatf("t6b valid%0d", k), 32'(v2), 32'd1);
                check($sformatf("t6b data%0d", k), d2, words[k]);
                check($sformatf("t6b last%0d", k), 32'(l2), 32'd1);
                check($sformatf("t6b rd_en%0d", k), 32'(rd2), 32'(k < 3));
                tick();
            end
            push_en[2] = 1'b0;
            #1;
            check("t6b end valid", 32'(v2), 32'd0);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
